// File: rtl/multicycle_controller.sv
// Multicycle processor control unit.
// Moore-style sequencer that walks each instruction through fetch, decode and
// the execute/memory/writeback steps of its opcode class. Outputs decode from
// the current state; a few strobes are further qualified by mem_ready or
// branch_taken in the states that own them.
//
// state    | meaning
// ---------+----------------------------------------------------------
// FETCH    | read instruction at PC, load IR and PC+4 when memory is ready
// DECODE   | compute branch/jump target into ALUOut, dispatch on opcode
// MEMADR   | compute load/store effective address rs1 + imm
// MEMREAD  | read data memory at ALUOut, wait for mem_ready
// MEMWB    | write loaded data to the register file
// MEMWRITE | write data memory at ALUOut, retire on mem_ready
// EXECR    | ALU operation rs1 op rs2
// EXECI    | ALU operation rs1 op imm
// ALUWB    | write ALUOut to the register file
// BRANCH   | compare rs1/rs2, load PC from ALUOut when taken
// JAL      | load PC from jump target, compute return address OldPC + 4
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic       illegal,
    output logic       instr_done
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // Next-state selection; memory states hold until mem_ready, others advance unconditionally.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register; reset drops straight back to FETCH without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Output decode from state. FETCH is the only state that can be active during
    // reset and its strobes follow mem_ready, so every strobe is also masked by
    // reset_n to keep IR/PC untouched while reset is held.
    always_comb begin
        mem_req    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        ResultSrc  = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                unique case (op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: illegal = 1'b0;
                    default:                                                   illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                AdrSrc     = 1'b1;
                MemWrite   = mem_ready;
                instr_done = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b11;
                PCWrite    = branch_taken;
                instr_done = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
        if (!reset_n) begin
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule
